// File: rtl/counter_checker.sv
// rtl/counter_checker.sv - passive monitor predicting a free-running counter and flagging deviations
module counter_checker #(
  parameter int WIDTH       = 4,
  parameter int ERR_W       = 8,
  parameter int FAULT_LIMIT = 3,
  parameter int WRAP_W      = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mon_reset,
  input  logic              mon_enable,
  input  logic [WIDTH-1:0]  mon_count,
  input  logic              clear_err,
  output logic              synced,
  output logic              mismatch,
  output logic [WIDTH-1:0]  expected,
  output logic [ERR_W-1:0]  error_count,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              fault
);

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t            state;
  state_t            state_n;
  logic              mismatch_n;
  logic [WIDTH-1:0]  expected_n;
  logic [ERR_W-1:0]  error_n;
  logic [ERR_W-1:0]  error_inc;
  logic [WRAP_W-1:0] wrap_n;
  logic              differs;

  assign synced = (state == TRACK);
  assign fault  = (state == FAULT);

  // Next-state and next-statistics decode; the prediction follows the observed
  // value so a single glitch costs one error rather than a cascade.
  always_comb begin
    state_n    = state;
    mismatch_n = 1'b0;
    expected_n = expected;
    error_n    = error_count;
    wrap_n     = wrap_count;
    differs    = (mon_count != expected);
    error_inc  = (differs && (error_count != ERR_MAX)) ? error_count + ERR_W'(1) : error_count;
    case (state)
      UNSYNC: begin
        if (clear_err) error_n = '0;
        if (mon_reset) begin
          expected_n = '0;
          state_n    = TRACK;
        end
      end
      TRACK: begin
        mismatch_n = differs;
        if (mon_reset)       expected_n = '0;
        else if (mon_enable) expected_n = mon_count + WIDTH'(1);
        else                 expected_n = mon_count;
        if (!mon_reset && mon_enable && (mon_count == CNT_MAX)) wrap_n = wrap_count + WRAP_W'(1);
        // A coincident clear beats both the increment and the fault entry.
        if (clear_err) begin
          error_n = '0;
        end else begin
          error_n = error_inc;
          if ((FAULT_LIMIT != 0) && (error_inc == ERR_W'(FAULT_LIMIT))) state_n = FAULT;
        end
      end
      FAULT: begin
        if (clear_err) begin
          error_n = '0;
          state_n = UNSYNC;
        end
      end
      default: state_n = UNSYNC;
    endcase
  end

  // State and statistics registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= UNSYNC;
      mismatch    <= 1'b0;
      expected    <= '0;
      error_count <= '0;
      wrap_count  <= '0;
    end else begin
      state       <= state_n;
      mismatch    <= mismatch_n;
      expected    <= expected_n;
      error_count <= error_n;
      wrap_count  <= wrap_n;
    end
  end

endmodule
